// File: rtl/datamem_axil_pkg.sv
// Shared definitions for the NPU data-memory AXI4-Lite slave.
// Holds the AXI response codes, the write/read channel state encodings and
// the word offsets (past the end of the memory) of the optional performance
// counters enabled by DATAMEM_PERF_CNT_EN.
package datamem_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Counter word offsets relative to word index MEM_DEPTH
    localparam int CNT_WR_WORD_OFS = 0;
    localparam int CNT_RD_WORD_OFS = 1;

endpackage

// File: rtl/datamem_ram.sv
// Word-organised data memory with per-byte write enables and a registered
// read port. Kept as a separate module so that block-RAM inference is not
// disturbed by the AXI control logic around it. Contents are not reset.
// A read and a write to the same word at the same edge return the old data.
//
// Ports:
//   clk_sys  clock
//   we       per-byte write enable (one bit per byte lane)
//   waddr    write word index
//   wdata    write data
//   re       read enable; rdata only changes when re is high
//   raddr    read word index
//   rdata    registered read data
module datamem_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic            clk_sys,
    input  logic [DW/8-1:0] we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_sys) begin
        for (int b = 0; b < DW/8; b++) begin
            if (we[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/datamem_axil_slave.sv
// AXI4-Lite slave in front of the NPU data memory. Independent write and read
// channels; word-wide accesses with byte strobes; out-of-range words answer
// SLVERR (reads return 0). All READY outputs are held low until the first
// clock edge after reset release.
//
// Optional build macro: DATAMEM_PERF_CNT_EN
//   Adds wr_cnt/rd_cnt (OKAY B / R handshakes), readable at byte addresses
//   MEM_DEPTH*4 and MEM_DEPTH*4+4. Without it those addresses are plain
//   out-of-range.
//
// Ports: ACLK / ARESETN (async, active low), and the s00_axi_* AW, W, B, AR
// and R channels. awprot/arprot and addr[1:0] are ignored.
//
// state      | meaning
// W_COLLECT  | gathering AW and W (either order); commit when both present
// W_RESP     | bvalid/bresp held until bready
// R_IDLE     | arready high; registered read on AR handshake
// R_DATA     | rvalid/rdata/rresp held until rready
module datamem_axil_slave
    import datamem_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int MEM_DEPTH          = 256
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int RAM_AW = $clog2(MEM_DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);

    logic rst_done;

    wr_state_t         wr_state;
    logic              aw_held, w_held;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DW-1:0]     wdata_q;
    logic [DW/8-1:0]   wstrb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    rd_state_t         rd_state;
    logic              rvalid_q;
    logic [1:0]        rresp_q;
    logic              rd_use_mem;
    logic [DW-1:0]     rd_alt_q;
    logic [DW-1:0]     ram_rdata;

    logic              aw_hs, w_hs, wr_commit, wr_in_range;
    logic [IDX_W-1:0]  wr_idx;
    logic [DW-1:0]     wr_data;
    logic [DW/8-1:0]   wr_strb, ram_we;
    logic              ar_hs, rd_in_range;
    logic [IDX_W-1:0]  rd_idx;

    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rst_done <= 1'b0;
        else          rst_done <= 1'b1;
    end

    // ---------------- write channel ----------------
    assign s00_axi_awready = rst_done & (wr_state == W_COLLECT) & ~aw_held;
    assign s00_axi_wready  = rst_done & (wr_state == W_COLLECT) & ~w_held;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;

    assign aw_hs = s00_axi_awvalid & s00_axi_awready;
    assign w_hs  = s00_axi_wvalid  & s00_axi_wready;

    // Held values take priority; the live bus is used when the beat
    // handshakes in the commit cycle itself.
    assign wr_idx      = aw_held ? aw_idx_q : s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_data     = w_held  ? wdata_q  : s00_axi_wdata;
    assign wr_strb     = w_held  ? wstrb_q  : s00_axi_wstrb;
    assign wr_commit   = (wr_state == W_COLLECT) & (aw_held | aw_hs) & (w_held | w_hs);
    assign wr_in_range = wr_idx < DEPTH_IDX;
    assign ram_we      = (wr_commit & wr_in_range) ? wr_strb : '0;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state <= W_COLLECT;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_COLLECT: begin
                    if (wr_commit) begin
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                        wr_state <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_held  <= 1'b1;
                            aw_idx_q <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                        end
                        if (w_hs) begin
                            w_held  <= 1'b1;
                            wdata_q <= s00_axi_wdata;
                            wstrb_q <= s00_axi_wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (s00_axi_bready) begin
                        bvalid_q <= 1'b0;
                        wr_state <= W_COLLECT;
                    end
                end
                default: wr_state <= W_COLLECT;
            endcase
        end
    end

    // ---------------- read channel ----------------
    assign s00_axi_arready = rst_done & (rd_state == R_IDLE);
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rresp   = rresp_q;
    // Non-memory results (SLVERR zero, counter snapshots) live in rd_alt_q so
    // rdata stays stable while R is stalled even if a counter moves.
    assign s00_axi_rdata   = rd_use_mem ? ram_rdata : rd_alt_q;

    assign ar_hs       = s00_axi_arvalid & s00_axi_arready;
    assign rd_idx      = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_in_range = rd_idx < DEPTH_IDX;

`ifdef DATAMEM_PERF_CNT_EN
    localparam logic [IDX_W-1:0] CNT_WR_IDX = IDX_W'(MEM_DEPTH + CNT_WR_WORD_OFS);
    localparam logic [IDX_W-1:0] CNT_RD_IDX = IDX_W'(MEM_DEPTH + CNT_RD_WORD_OFS);

    logic [31:0] wr_cnt, rd_cnt;
    logic        rd_is_cnt_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (bvalid_q && s00_axi_bready && bresp_q == RESP_OKAY)
                wr_cnt <= wr_cnt + 32'd1;
            if (rvalid_q && s00_axi_rready && rresp_q == RESP_OKAY && !rd_is_cnt_q)
                rd_cnt <= rd_cnt + 32'd1;
        end
    end
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state    <= R_IDLE;
            rvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rd_use_mem  <= 1'b0;
            rd_alt_q    <= '0;
`ifdef DATAMEM_PERF_CNT_EN
            rd_is_cnt_q <= 1'b0;
`endif
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rvalid_q   <= 1'b1;
                        rd_state   <= R_DATA;
                        rd_use_mem <= rd_in_range;
                        rresp_q    <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        rd_alt_q   <= '0;
`ifdef DATAMEM_PERF_CNT_EN
                        rd_is_cnt_q <= 1'b0;
                        if (rd_idx == CNT_WR_IDX) begin
                            rresp_q     <= RESP_OKAY;
                            rd_alt_q    <= DW'(wr_cnt);
                            rd_is_cnt_q <= 1'b1;
                        end else if (rd_idx == CNT_RD_IDX) begin
                            rresp_q     <= RESP_OKAY;
                            rd_alt_q    <= DW'(rd_cnt);
                            rd_is_cnt_q <= 1'b1;
                        end
`endif
                    end
                end
                R_DATA: begin
                    if (s00_axi_rready) begin
                        rvalid_q <= 1'b0;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    datamem_ram #(
        .DEPTH (MEM_DEPTH),
        .AW    (RAM_AW),
        .DW    (DW)
    ) u_ram (
        .clk_sys (ACLK),
        .we      (ram_we),
        .waddr   (wr_idx[RAM_AW-1:0]),
        .wdata   (wr_data),
        .re      (ar_hs & rd_in_range),
        .raddr   (rd_idx[RAM_AW-1:0]),
        .rdata   (ram_rdata)
    );

endmodule

// File: tb/tb_datamem_axil_slave.sv
module tb_datamem_axil_slave;

    localparam int LIM = 50;

    logic        ACLK;
    logic        ARESETN;
    logic [11:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int tests = 0;
    int fails = 0;

    logic [31:0] rd_d;
    logic [1:0]  rsp;

    datamem_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (12),
        .MEM_DEPTH          (256)
    ) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {25'd0, awready, wready, bvalid, bresp, arready, rvalid}, 32'd0);
        check({tag, "_rresp"}, {30'd0, rresp}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
    endtask

    // Called at a negedge; returns at a negedge after the B handshake.
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int   n;
        logic ag, wg;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; n = 0;
        while ((awvalid || wvalid) && n < LIM) begin
            ag = awvalid & awready;
            wg = wvalid & wready;
            @(negedge ACLK); n++;
            if (ag) awvalid = 1'b0;
            if (wg) wvalid = 1'b0;
        end
        bready = 1'b1;
        while (!bvalid && n < LIM) begin
            @(negedge ACLK); n++;
        end
        resp = bresp;
        @(negedge ACLK);
        bready = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_in_budget", (n < LIM) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        int   n;
        logic ag;
        araddr = a; arvalid = 1'b1; n = 0;
        while (arvalid && n < LIM) begin
            ag = arready;
            @(negedge ACLK); n++;
            if (ag) arvalid = 1'b0;
        end
        rready = 1'b1;
        while (!rvalid && n < LIM) begin
            @(negedge ACLK); n++;
        end
        d = rdata; resp = rresp;
        @(negedge ACLK);
        rready = 1'b0;
        arvalid = 1'b0;
        check("rd_in_budget", (n < LIM) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        ARESETN = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        // reset state and READY gating after release
        repeat (3) @(negedge ACLK);
        check_quiet("reset");
        ARESETN = 1'b1;
        #1;
        check("rdy_at_release", {30'd0, awready, arready}, 32'd0);
        @(negedge ACLK);
        check("rdy_after_1cyc", {29'd0, awready, wready, arready}, 32'd7);

        // four writes then readback
        for (int i = 0; i < 4; i++) begin
            axi_write(12'(4*i), 32'(i+1), 4'hF, rsp);
            check("wr_seq_bresp", {30'd0, rsp}, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(12'(4*i), rd_d, rsp);
            check("rd_seq_data", rd_d, 32'(i+1));
            check("rd_seq_rresp", {30'd0, rsp}, 32'd0);
        end

        // W leads AW by three cycles
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        check("w_first_wready", {31'd0, wready}, 32'd1);
        @(negedge ACLK);
        wvalid = 1'b0;
        check("w_held_wready", {31'd0, wready}, 32'd0);
        check("w_only_bvalid1", {31'd0, bvalid}, 32'd0);
        @(negedge ACLK);
        check("w_only_bvalid2", {31'd0, bvalid}, 32'd0);
        @(negedge ACLK);
        check("w_only_bvalid3", {31'd0, bvalid}, 32'd0);
        awaddr = 12'h010; awvalid = 1'b1;
        check("aw_late_awready", {31'd0, awready}, 32'd1);
        @(negedge ACLK);
        awvalid = 1'b0;
        check("aw_late_bvalid", {31'd0, bvalid}, 32'd1);
        check("aw_late_bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        @(negedge ACLK);
        bready = 1'b0;
        check("aw_late_bdone", {31'd0, bvalid}, 32'd0);
        axi_read(12'h010, rd_d, rsp);
        check("aw_late_readback", rd_d, 32'hDEADBEEF);

        // byte strobes
        axi_write(12'h020, 32'hAABBCCDD, 4'hF, rsp);
        axi_write(12'h020, 32'h11223344, 4'b0101, rsp);
        check("strb_bresp", {30'd0, rsp}, 32'd0);
        axi_read(12'h020, rd_d, rsp);
        check("strb_readback", rd_d, 32'hAA22CC44);
        axi_write(12'h020, 32'h99999999, 4'b0000, rsp);
        check("strb0_bresp", {30'd0, rsp}, 32'd0);
        axi_read(12'h020, rd_d, rsp);
        check("strb0_readback", rd_d, 32'hAA22CC44);

        // out of range
        axi_write(12'h400, 32'h12345678, 4'hF, rsp);
        check("oor_bresp", {30'd0, rsp}, 32'd2);
        axi_read(12'h7FC, rd_d, rsp);
        check("oor_rresp", {30'd0, rsp}, 32'd2);
        check("oor_rdata", rd_d, 32'd0);
        axi_read(12'h000, rd_d, rsp);
        check("oor_mem0_intact", rd_d, 32'd1);

        // read and write of the same word at one edge: read sees old data
        awaddr = 12'h008; wdata = 32'h00000099; wstrb = 4'hF; araddr = 12'h008;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge ACLK);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rw_same_rvalid", {30'd0, bvalid, rvalid}, 32'd3);
        check("rw_same_old", rdata, 32'd3);
        bready = 1'b1; rready = 1'b1;
        @(negedge ACLK);
        bready = 1'b0; rready = 1'b0;
        check("rw_same_done", {30'd0, bvalid, rvalid}, 32'd0);
        axi_read(12'h008, rd_d, rsp);
        check("rw_same_new", rd_d, 32'h00000099);

        // backpressure on B
        awaddr = 12'h030; wdata = 32'h00000055; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bstall_state", {27'd0, bvalid, bresp, awready, wready}, 32'h10);
            @(negedge ACLK);
        end
        bready = 1'b1;
        @(negedge ACLK);
        bready = 1'b0;
        check("bstall_release", {30'd0, bvalid, awready}, 32'd1);

        // backpressure on R
        araddr = 12'h030; arvalid = 1'b1;
        @(negedge ACLK);
        arvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("rstall_ctl", {28'd0, rvalid, rresp, arready}, 32'h8);
            check("rstall_data", rdata, 32'h00000055);
            @(negedge ACLK);
        end
        rready = 1'b1;
        @(negedge ACLK);
        rready = 1'b0;
        check("rstall_release", {30'd0, rvalid, arready}, 32'd1);
        axi_read(12'h004, rd_d, rsp);
        check("after_stall_read", rd_d, 32'd2);

        // reset with B and R pending
        awaddr = 12'h040; wdata = 32'h00000077; wstrb = 4'hF; araddr = 12'h000;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge ACLK);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("pre_rst_pending", {30'd0, bvalid, rvalid}, 32'd3);
        #2;
        ARESETN = 1'b0;
        #1;
        check_quiet("mid_rst");
        @(negedge ACLK);
        check_quiet("mid_rst_hold");
        ARESETN = 1'b1;
        #1;
        check("post_rst_rdy0", {29'd0, awready, wready, arready}, 32'd0);
        @(negedge ACLK);
        check("post_rst_rdy1", {29'd0, awready, wready, arready}, 32'd7);
        check("post_rst_no_stale", {30'd0, bvalid, rvalid}, 32'd0);
        check("post_rst_rdata", rdata, 32'd0);

`ifdef DATAMEM_PERF_CNT_EN
        for (int i = 0; i < 5; i++) begin
            axi_write(12'(12'h050 + 4*i), 32'(i), 4'hF, rsp);
        end
        axi_read(12'h400, rd_d, rsp);
        check("perf_wr_cnt", rd_d, 32'd5);
        check("perf_wr_rresp", {30'd0, rsp}, 32'd0);
        axi_read(12'h404, rd_d, rsp);
        check("perf_rd_cnt", rd_d, 32'd0);
        axi_read(12'h050, rd_d, rsp);
        axi_write(12'h400, 32'hFFFFFFFF, 4'hF, rsp);
        check("perf_wr_slverr", {30'd0, rsp}, 32'd2);
        axi_read(12'h404, rd_d, rsp);
        check("perf_rd_cnt_1", rd_d, 32'd1);
        axi_read(12'h400, rd_d, rsp);
        check("perf_wr_cnt_kept", rd_d, 32'd5);
`else
        axi_read(12'h400, rd_d, rsp);
        check("nocnt_rresp", {30'd0, rsp}, 32'd2);
        check("nocnt_rdata", rd_d, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
